ham_decoder: RTL and testbench

HAM_DECODER -- requirements
Module: ham_decoder

---
 rtl/ham_decoder.sv | 67 ++++++
 tb/tb_ham_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ham_decoder.sv
// Hamming(7,4) single-error-correcting decoder with a one-cycle registered output.
// Optional corrected-word counter is compiled in with the HAM_ERR_CNT_EN macro.
module ham_decoder #(
   parameter int unsigned CNT_W = 8
) (
   output logic [3:0] data,
   input  logic [6:0] enc_ham_data,
   output logic [2:0] pos_error,
   output logic       error,
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       out_valid
`ifdef HAM_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("ham_decoder: CNT_W must be at least 1");
   end

   logic [2:0] syn;
   logic [6:0] fixed;
   logic [3:0] dec;

   // enc_ham_data[k] carries codeword position k+1
   always_comb begin
      syn[0] = enc_ham_data[0] ^ enc_ham_data[2] ^ enc_ham_data[4] ^ enc_ham_data[6];
      syn[1] = enc_ham_data[1] ^ enc_ham_data[2] ^ enc_ham_data[5] ^ enc_ham_data[6];
      syn[2] = enc_ham_data[3] ^ enc_ham_data[4] ^ enc_ham_data[5] ^ enc_ham_data[6];
      fixed  = enc_ham_data;
      if (syn != '0) begin
         fixed[syn - 3'd1] = ~enc_ham_data[syn - 3'd1];
      end
      dec = {fixed[6], fixed[5], fixed[4], fixed[2]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         pos_error <= '0;
         error     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data      <= dec;
            pos_error <= syn;
            error     <= (syn != '0);
         end
      end
   end

`ifdef HAM_ERR_CNT_EN
   // Counts on the same edge that registers error=1; sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (in_valid && (syn != '0) && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ham_decoder.sv
// Directed self-checking bench for ham_decoder: vector table, exhaustive
// single-bit-error sweep, mid-stream reset and (with HAM_ERR_CNT_EN) counter saturation.
module tb_ham_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] enc_ham_data = '0;
   logic       in_valid = 1'b0;
   logic [3:0] data;
   logic [2:0] pos_error;
   logic       error;
   logic       out_valid;

   int n_vec = 0;
   int n_bad = 0;

`ifdef HAM_ERR_CNT_EN
   logic [1:0] err_cnt;
   ham_decoder #(.CNT_W(2)) dut (
      .data(data), .enc_ham_data(enc_ham_data), .pos_error(pos_error), .error(error),
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(out_valid),
      .err_cnt(err_cnt)
   );
`else
   ham_decoder dut (
      .data(data), .enc_ham_data(enc_ham_data), .pos_error(pos_error), .error(error),
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(out_valid)
   );
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] enc;
      logic       vin;
      logic [3:0] e_data;
      logic [2:0] e_pos;
      logic       e_err;
      logic       e_ov;
   } vec_t;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      // positions 7..1 = d3 d2 d1 p4 d0 p2 p1
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   task automatic drive(input logic [6:0] w, input logic v);
      enc_ham_data = w;
      in_valid     = v;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{7'b1010101, 1'b1, 4'b1011, 3'd0, 1'b0, 1'b1}; // clean
      tbl[1]  = '{7'b1010001, 1'b1, 4'b1011, 3'd3, 1'b1, 1'b1}; // pos3 flipped
      tbl[2]  = '{7'b1010100, 1'b1, 4'b1011, 3'd1, 1'b1, 1'b1}; // pos1 flipped
      tbl[3]  = '{7'b0000000, 1'b0, 4'b1011, 3'd1, 1'b1, 1'b0}; // hold
      tbl[4]  = '{7'b0000000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1};
      tbl[5]  = '{7'b1111111, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b1};
      tbl[6]  = '{7'b0111111, 1'b1, 4'b1111, 3'd7, 1'b1, 1'b1}; // pos7 flipped
      tbl[7]  = '{7'b1111110, 1'b0, 4'b1111, 3'd7, 1'b1, 1'b0}; // hold
      tbl[8]  = '{7'b1010111, 1'b1, 4'b1011, 3'd2, 1'b1, 1'b1}; // pos2 flipped
      tbl[9]  = '{7'b1011101, 1'b1, 4'b1011, 3'd4, 1'b1, 1'b1}; // pos4 flipped
      tbl[10] = '{7'b1010110, 1'b1, 4'b1010, 3'd3, 1'b1, 1'b1}; // pos1+2: miscorrect

      // reset state, asserted asynchronously before any clock edge matters
      #2;
      check("reset data", {4'b0, data}, 8'h00);
      check("reset pos", {5'b0, pos_error}, 8'h00);
      check("reset err", {7'b0, error}, 8'h00);
      check("reset ov", {7'b0, out_valid}, 8'h00);
`ifdef HAM_ERR_CNT_EN
      check("reset cnt", {6'b0, err_cnt}, 8'h00);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // first word taken on the first edge after release
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].enc, tbl[i].vin);
         check($sformatf("tbl%0d data", i), {4'b0, data}, {4'b0, tbl[i].e_data});
         check($sformatf("tbl%0d pos", i), {5'b0, pos_error}, {5'b0, tbl[i].e_pos});
         check($sformatf("tbl%0d err", i), {7'b0, error}, {7'b0, tbl[i].e_err});
         check($sformatf("tbl%0d ov", i), {7'b0, out_valid}, {7'b0, tbl[i].e_ov});
      end

      // exhaustive single-bit errors, streamed with in_valid held high
      for (int n = 0; n < 16; n++) begin
         for (int p = 1; p <= 7; p++) begin
            logic [6:0] w;
            w = encode(4'(n));
            w[p-1] = ~w[p-1];
            drive(w, 1'b1);
            check($sformatf("sweep n%0d p%0d", n, p),
                  {out_valid, error, pos_error, data[2:0]} ^ {4'b0, data[3], 3'b0},
                  {1'b1, 1'b1, 3'(p), 3'(n)} ^ {4'b0, 1'(n >> 3), 3'b0});
            check($sformatf("sweep n%0d p%0d d3", n, p), {7'b0, data[3]}, {7'b0, 1'(n >> 3)});
         end
      end

      // reset while a word is in flight
      enc_ham_data = 7'b1010101;
      in_valid     = 1'b1;
      @(posedge clk);
      #2;
      check("pre-rst ov", {7'b0, out_valid}, 8'h01);
      rst_n = 1'b0;
      #1;
      check("mid-rst outs", {out_valid, error, pos_error, data[2:0]}, 8'h00);
      check("mid-rst d3", {7'b0, data[3]}, 8'h00);
      @(posedge clk);
      #1;
      check("rst held ov", {7'b0, out_valid}, 8'h00);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post-rst no stale ov", {7'b0, out_valid}, 8'h00);
      drive(7'b1010001, 1'b1);
      check("post-rst word", {out_valid, error, pos_error, data[2:0]}, {1'b1, 1'b1, 3'd3, 3'b011});
      drive(7'b0, 1'b0);
      check("post-rst ov drop", {7'b0, out_valid}, 8'h00);

`ifdef HAM_ERR_CNT_EN
      rst_n = 1'b0;
      #1;
      check("cnt reset", {6'b0, err_cnt}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [1:0] e;
         e = (i < 3) ? 2'(i + 1) : 2'd3;
         drive(7'b1010100, 1'b1);
         check($sformatf("cnt word%0d", i), {6'b0, err_cnt}, {6'b0, e});
      end
      drive(7'b1010101, 1'b1);
      check("cnt clean hold", {6'b0, err_cnt}, 8'h03);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
